// File: rtl/dnn_pkg.sv
// Shared types and constants for the dot-product accelerator batch driver.
package dnn_pkg;
    localparam int DNN_ELEM_W = 16;
    localparam int DNN_RES_W  = 32;
    localparam int DNN_BATCH  = 64;
    localparam int DNN_IDX_W  = 6;
    localparam int DNN_CNT_W  = 7;

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_FULL, RD_REQ, COLLECT, DRAIN, DONE
    } drv_state_t;

    typedef struct packed {
        logic [DNN_IDX_W-1:0] idx;
        logic [DNN_RES_W-1:0] data;
    } res_entry_t;
endpackage

// File: rtl/dnn_res_fifo.sv
// Synchronous result FIFO with a registered head: storage array feeds a head
// register, so data reaches the head one cycle after it is written.
module dnn_res_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 64,
    parameter int CW    = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic             do_pop, load, do_push;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = head_vld && pop;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign load    = (mem_cnt != '0) && (!head_vld || do_pop);
    assign do_push = push && ((mem_cnt != CW'(DEPTH)) || load);
    assign count   = mem_cnt + CW'(head_vld);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            head_vld  <= 1'b0;
            head_data <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            head_vld  <= 1'b0;
            head_data <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            case ({do_push, load})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: ;
            endcase
            if (load) begin
                head_data <= mem[rd_ptr];
                head_vld  <= 1'b1;
                rd_ptr    <= ptr_inc(rd_ptr);
            end else if (do_pop) begin
                head_vld  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/dnn_batch_driver.sv
// Batch initiator for the accelerator MAC/readMem interface: issues BATCH ops,
// reads the result buffer back and streams results out. Optional watchdog: DNN_DRV_TIMEOUT_EN.
module dnn_batch_driver
    import dnn_pkg::*;
#(
    parameter int BATCH          = DNN_BATCH,
    parameter int RES_FIFO_DEPTH = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [63:0]           src_vecA,
    input  logic [63:0]           src_vecB,
    output logic                  EN_mac,
    output logic [DNN_ELEM_W-1:0] mac_vecA_0,
    output logic [DNN_ELEM_W-1:0] mac_vecA_1,
    output logic [DNN_ELEM_W-1:0] mac_vecA_2,
    output logic [DNN_ELEM_W-1:0] mac_vecA_3,
    output logic [DNN_ELEM_W-1:0] mac_vecB_0,
    output logic [DNN_ELEM_W-1:0] mac_vecB_1,
    output logic [DNN_ELEM_W-1:0] mac_vecB_2,
    output logic [DNN_ELEM_W-1:0] mac_vecB_3,
    input  logic                  RDY_mac,
    output logic                  EN_readMem,
    input  logic                  VALID_memVal,
    input  logic [DNN_RES_W-1:0]  memVal_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DNN_RES_W-1:0]  res_data,
    output logic [DNN_IDX_W-1:0]  res_idx
);
    localparam int ENTRY_W = $bits(res_entry_t);
    localparam int FIFO_CW = $clog2(RES_FIFO_DEPTH + 2);

    if (RES_FIFO_DEPTH < BATCH || BATCH > (1 << DNN_IDX_W) || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("dnn_batch_driver: RES_FIFO_DEPTH must be >= BATCH, BATCH <= 64, TIMEOUT_CYCLES >= 1");
    end

    drv_state_t           state_q, state_d;
    logic [DNN_CNT_W-1:0] issue_cnt, rx_cnt;
    logic                 accept, fire, beat, wd_to, flush;
    logic [FIFO_CW-1:0]   fifo_cnt;
    logic [ENTRY_W-1:0]   head_raw;
    res_entry_t           wentry, hentry;

    assign mac_vecA_0 = src_vecA[15:0];
    assign mac_vecA_1 = src_vecA[31:16];
    assign mac_vecA_2 = src_vecA[47:32];
    assign mac_vecA_3 = src_vecA[63:48];
    assign mac_vecB_0 = src_vecB[15:0];
    assign mac_vecB_1 = src_vecB[31:16];
    assign mac_vecB_2 = src_vecB[47:32];
    assign mac_vecB_3 = src_vecB[63:48];

    assign accept = (state_q == IDLE) && start;
    assign fire   = (state_q == ISSUE) && src_valid && RDY_mac;
    assign beat   = (state_q == COLLECT) && VALID_memVal;

    always_comb begin
        state_d    = state_q;
        busy       = (state_q != IDLE);
        src_ready  = 1'b0;
        EN_mac     = 1'b0;
        EN_readMem = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE:      if (start) state_d = ISSUE;
            ISSUE: begin
                src_ready = fire;
                EN_mac    = fire;
                if (fire && issue_cnt == DNN_CNT_W'(BATCH - 1)) state_d = WAIT_FULL;
            end
            // RDY_mac dropping is the accelerator's "result buffer full" indication.
            WAIT_FULL: if (!RDY_mac) state_d = RD_REQ;
            RD_REQ: begin
                EN_readMem = 1'b1;
                state_d    = COLLECT;
            end
            COLLECT:   if (beat && rx_cnt == DNN_CNT_W'(BATCH - 1)) state_d = DRAIN;
            DRAIN:     if (fifo_cnt == '0) state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
        if (wd_to) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            issue_cnt <= '0;
            rx_cnt    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                issue_cnt <= '0;
                rx_cnt    <= '0;
            end else begin
                if (fire) issue_cnt <= issue_cnt + 1'b1;
                if (beat) rx_cnt    <= rx_cnt + 1'b1;
            end
        end
    end

`ifdef DNN_DRV_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            waiting;

    assign waiting = (state_q == WAIT_FULL) || (state_q == COLLECT);
    assign wd_to   = waiting && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q != state_d) wd_cnt <= '0;
            else if (waiting)       wd_cnt <= wd_cnt + 1'b1;
            if (accept)     err_q <= 1'b0;
            else if (wd_to) err_q <= 1'b1;
        end
    end
`else
    assign wd_to = 1'b0;
    assign err   = 1'b0;
`endif

    // A timed-out batch leaves partial results behind; discard them.
    assign flush  = wd_to;
    assign wentry = '{idx: rx_cnt[DNN_IDX_W-1:0], data: memVal_data};
    assign hentry = res_entry_t'(head_raw);

    dnn_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (RES_FIFO_DEPTH),
        .CW    (FIFO_CW)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (beat),
        .wdata     (wentry),
        .pop       (res_ready),
        .head_vld  (res_valid),
        .head_data (head_raw),
        .count     (fifo_cnt)
    );

    assign res_data = hentry.data;
    assign res_idx  = hentry.idx;
endmodule

// File: tb/tb_dnn_batch_driver.sv
// Directed bench for dnn_batch_driver: combinational vector table plus
// hand-written full-batch sequences with a small accelerator model.
module tb_dnn_batch_driver;
`ifdef DNN_DRV_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam int NB = 64;

    logic        clk = 1'b0, rst_n, start, busy, done, err;
    logic        src_valid, src_ready, EN_mac, RDY_mac, EN_readMem, VALID_memVal;
    logic [63:0] src_vecA, src_vecB;
    logic [15:0] mac_vecA_0, mac_vecA_1, mac_vecA_2, mac_vecA_3;
    logic [15:0] mac_vecB_0, mac_vecB_1, mac_vecB_2, mac_vecB_3;
    logic [31:0] memVal_data, res_data;
    logic        res_valid, res_ready;
    logic [5:0]  res_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dnn_batch_driver #(.BATCH(NB), .RES_FIFO_DEPTH(64), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .src_valid(src_valid), .src_ready(src_ready), .src_vecA(src_vecA), .src_vecB(src_vecB),
        .EN_mac(EN_mac),
        .mac_vecA_0(mac_vecA_0), .mac_vecA_1(mac_vecA_1), .mac_vecA_2(mac_vecA_2), .mac_vecA_3(mac_vecA_3),
        .mac_vecB_0(mac_vecB_0), .mac_vecB_1(mac_vecB_1), .mac_vecB_2(mac_vecB_2), .mac_vecB_3(mac_vecB_3),
        .RDY_mac(RDY_mac), .EN_readMem(EN_readMem), .VALID_memVal(VALID_memVal),
        .memVal_data(memVal_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx)
    );

    typedef struct {
        logic [63:0] a, b;
        logic [15:0] ea0, ea1, ea2, ea3, eb0, eb1, eb2, eb3;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_en_mac"}, EN_mac, 0);
        chk({tag, "_en_readmem"}, EN_readMem, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_idx"}, res_idx, 0);
    endtask

    // Every call starts and ends at posedge+1 with the DUT idle.
    task automatic do_batch(input bit toggle, input bit stall, input bit poke, input int abort_at);
        int fires = 0, cyc = 0, en_err = 0, early_vld = 0;
        int k = 0, pops = 0, rd_cnt = 0, done_cnt = 0, data_err = 0;
        int fb = -1, fv = -1;
        bit collecting = 0, released = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        src_valid = 1'b1;
        res_ready = 1'b1;
        while (fires < NB && cyc < 1000) begin
            if (fires == abort_at) return;
            RDY_mac      = toggle ? (cyc % 2 == 0) : 1'b1;
            src_vecA     = {16'(fires + 3), 16'(fires + 2), 16'(fires + 1), 16'(fires)};
            src_vecB     = {16'hB000 | 16'(fires), 48'h0};
            VALID_memVal = poke && (cyc == 5);
            memVal_data  = 32'hBAD;
            @(negedge clk);
            if (EN_mac !== RDY_mac || src_ready !== EN_mac || busy !== 1'b1) en_err++;
            if (EN_mac && (mac_vecA_0 !== 16'(fires) || mac_vecB_3 !== (16'hB000 | 16'(fires)))) en_err++;
            if (res_valid) early_vld++;
            if (EN_mac) fires++;
            @(posedge clk); #1;
            cyc++;
        end
        VALID_memVal = 1'b0;
        RDY_mac      = 1'b0;
        src_valid    = 1'b0;
        chk("issue_fires", fires, NB);
        chk("issue_cycles", cyc, toggle ? 127 : 64);
        chk("issue_handshake_err", en_err, 0);
        chk("issue_res_valid", early_vld, 0);

        for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
            VALID_memVal = collecting && (k < NB);
            memVal_data  = 32'(k * 3);
            res_ready    = !stall || released;
            start        = poke && (k == 10);
            if (VALID_memVal && fb < 0) fb = c;
            @(negedge clk);
            if (EN_readMem) begin
                rd_cnt++;
                collecting = 1'b1;
            end
            if (res_valid && fv < 0) fv = c;
            if (res_valid && res_ready) begin
                if (res_idx !== 6'(pops) || res_data !== 32'(pops * 3)) data_err++;
                pops++;
            end
            if (done) done_cnt++;
            if (stall && !released && k == NB && !VALID_memVal) begin
                chk("stall_no_pop", pops, 0);
                chk("stall_head_valid", res_valid, 1);
                chk("stall_head_idx", res_idx, 0);
                chk("stall_busy", busy, 1);
                released = 1'b1;
            end
            if (VALID_memVal) k++;
            @(posedge clk); #1;
        end
        start        = 1'b0;
        VALID_memVal = 1'b0;
        chk("readmem_pulses", rd_cnt, 1);
        chk("pops_at_done", pops, NB);
        chk("pop_order_err", data_err, 0);
        chk("done_pulses", done_cnt, 1);
        if (!stall) chk("first_res_latency", fv - fb, 2);
        @(negedge clk);
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_res_valid", res_valid, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        tbl[0] = '{64'h0004_0003_0002_0001, 64'h0000_0000_0000_0000,
                   16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{64'hFFFF_8000_7FFF_0000, 64'h1234_5678_9ABC_DEF0,
                   16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
        tbl[2] = '{64'hDEAD_BEEF_CAFE_F00D, 64'hA5A5_5A5A_0F0F_F0F0,
                   16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD, 16'hF0F0, 16'h0F0F, 16'h5A5A, 16'hA5A5};
        tbl[3] = '{64'h0000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                   16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

        rst_n = 1'b0; start = 1'b0; src_valid = 1'b1; RDY_mac = 1'b1;
        src_vecA = '0; src_vecB = '0; VALID_memVal = 1'b0; memVal_data = '0; res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_outs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1; src_valid = 1'b0; RDY_mac = 1'b0;

        for (int i = 0; i < 4; i++) begin
            src_vecA = tbl[i].a;
            src_vecB = tbl[i].b;
            @(negedge clk);
            chk("mac_vecA_0", mac_vecA_0, tbl[i].ea0);
            chk("mac_vecA_1", mac_vecA_1, tbl[i].ea1);
            chk("mac_vecA_2", mac_vecA_2, tbl[i].ea2);
            chk("mac_vecA_3", mac_vecA_3, tbl[i].ea3);
            chk("mac_vecB_0", mac_vecB_0, tbl[i].eb0);
            chk("mac_vecB_1", mac_vecB_1, tbl[i].eb1);
            chk("mac_vecB_2", mac_vecB_2, tbl[i].eb2);
            chk("mac_vecB_3", mac_vecB_3, tbl[i].eb3);
            chk("idle_src_ready", src_ready, 0);
            @(posedge clk); #1;
        end

        do_batch(1'b0, 1'b0, 1'b0, 99);   // basic batch
        do_batch(1'b1, 1'b0, 1'b0, 99);   // RDY_mac toggling
        do_batch(1'b0, 1'b1, 1'b0, 99);   // downstream stalled through COLLECT
        do_batch(1'b0, 1'b0, 1'b1, 99);   // stray start / VALID_memVal

        do_batch(1'b0, 1'b0, 1'b0, 30);   // abort by reset at op 30
        rst_n = 1'b0;
        @(negedge clk);
        chk_outs_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1; src_valid = 1'b0; RDY_mac = 1'b0;
        do_batch(1'b0, 1'b0, 1'b0, 99);

`ifdef DNN_DRV_TIMEOUT_EN
        begin
            int f = 0, n = 0, dn = 0;
            bit seen = 0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; src_valid = 1'b1; RDY_mac = 1'b1;
            for (int c = 0; c < 200 && f < NB; c++) begin
                @(negedge clk);
                if (EN_mac) f++;
                @(posedge clk); #1;
            end
            src_valid = 1'b0;
            while (!seen && n < 100) begin
                @(negedge clk);
                if (done) dn++;
                if (err) seen = 1'b1;
                else n++;
                @(posedge clk); #1;
            end
            chk("to_fires", f, NB);
            chk("to_cycles", n, TO);
            chk("to_err", seen, 1);
            chk("to_idle", busy, 0);
            chk("to_no_done", dn, 0);
            RDY_mac = 1'b0;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("to_err_cleared", err, 0);
            chk("to_restart_busy", busy, 1);
            @(posedge clk); #1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
